// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types.
//   word_t          - 32-bit machine word
//   aluop_t         - 4-bit ALU opcode
//   alu_arb_state_t - state encoding of the shared-ALU arbiter
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_ADD = 4'h0,
        ALU_SUB = 4'h1,
        ALU_AND = 4'h2,
        ALU_OR  = 4'h3,
        ALU_XOR = 4'h4,
        ALU_SLT = 4'h5,
        ALU_SLL = 4'h6,
        ALU_SRL = 4'h7
    } aluop_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_RESP} alu_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   req_i   - request vector
//   ptr_i   - index with highest priority this cycle
//   grant_o - one-hot grant (all zero when nothing requests)
//   idx_o   - index of the granted bit
//   any_o   - at least one request is set
module rr_pick #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] grant_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);

    int unsigned k;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        k       = 0;
        // Walk ptr, ptr+1, ... modulo N; the first set bit wins.
        for (int unsigned i = 0; i < N; i++) begin
            k = 32'(ptr_i) + i;
            if (k >= N) k = k - N;
            if (!any_o && req_i[k]) begin
                any_o      = 1'b1;
                idx_o      = W'(k);
                grant_o[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between NREQ requesters.
//   CLK/RST                - clock, synchronous active-high reset
//   req_valid/op/a/b       - per-requester request channel
//   req_ready              - one-hot grant, only in IDLE
//   rsp_valid/rsp_ready    - one-hot response channel to the accepted requester
//   rsp_out/zero/overflow/negative - captured ALU result and flags
//   alu_op/alu_in1/alu_in2 - registered operands to the external ALU
//   alu_out/zero/overflow/negative - ALU results
module alu_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned NREQ = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic      [NREQ-1:0] req_valid,
    input  aluop_t    [NREQ-1:0] req_op,
    input  word_t     [NREQ-1:0] req_a,
    input  word_t     [NREQ-1:0] req_b,
    output logic      [NREQ-1:0] req_ready,
    output logic      [NREQ-1:0] rsp_valid,
    input  logic      [NREQ-1:0] rsp_ready,
    output word_t                rsp_out,
    output logic                 rsp_zero,
    output logic                 rsp_overflow,
    output logic                 rsp_negative,
    output aluop_t               alu_op,
    output word_t                alu_in1,
    output word_t                alu_in2,
    input  word_t                alu_out,
    input  logic                 alu_zero,
    input  logic                 alu_overflow,
    input  logic                 alu_negative
);

    localparam int unsigned PTRW = (NREQ > 2) ? $clog2(NREQ) : 1;

    alu_arb_state_t  state_q, state_d;
    logic [PTRW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTRW-1:0] gidx_q, gidx_d;
    aluop_t          op_q, op_d;
    word_t           a_q, a_d, b_q, b_d;
    word_t           out_q, out_d;
    logic            zero_q, zero_d, ovf_q, ovf_d, neg_q, neg_d;

    logic [NREQ-1:0] pick_grant;
    logic [PTRW-1:0] pick_idx;
    logic            pick_any;

    rr_pick #(
        .N (NREQ),
        .W (PTRW)
    ) u_rr_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gidx_d   = gidx_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        neg_d    = neg_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    op_d     = req_op[pick_idx];
                    a_d      = req_a[pick_idx];
                    b_d      = req_b[pick_idx];
                    gidx_d   = pick_idx;
                    rr_ptr_d = (pick_idx == PTRW'(NREQ - 1)) ? '0 : pick_idx + PTRW'(1);
                    state_d  = ARB_EXEC;
                end
            end
            ARB_EXEC: begin
                out_d   = alu_out;
                zero_d  = alu_zero;
                ovf_d   = alu_overflow;
                neg_d   = alu_negative;
                state_d = ARB_RESP;
            end
            ARB_RESP: begin
                if (rsp_ready[gidx_q]) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == ARB_IDLE) ? pick_grant : '0;
        rsp_valid = '0;
        if (state_q == ARB_RESP) rsp_valid[gidx_q] = 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            gidx_q   <= '0;
            op_q     <= ALU_ADD;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gidx_q   <= gidx_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            neg_q    <= neg_d;
        end
    end

    assign alu_op       = op_q;
    assign alu_in1      = a_q;
    assign alu_in2      = b_q;
    assign rsp_out      = out_q;
    assign rsp_zero     = zero_q;
    assign rsp_overflow = ovf_q;
    assign rsp_negative = neg_q;

endmodule
